online_digit_collector: RTL and testbench

Downstream stage of `multiply_add_1D`: consumes its MSDF radix-4 signed-digit output stream `y` and assembles a conventional two's-complement parallel result. It discards the first DELAY digits (the online delay of the upstream stage), then collects DIGITS digits. On completion it emits a one-cycle `out_valid` pulse with the fixed-point result, and then accepts the next stream.

---
 rtl/online_digit_collector.sv | 133 +++++++++++++
 tb/tb_online_digit_collector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/online_digit_collector.sv
// Collects an MSDF radix-4 signed-digit stream into a two's-complement result.
// Optional macro ONLINE_OTF_CONVERSION_EN selects on-the-fly Q/QM conversion.
module online_digit_collector #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DELAY  = 2,
  localparam int unsigned OUT_W = 2 * DIGITS + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       y,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned SKIP_W = (DELAY < 2) ? 1 : $clog2(DELAY);
  localparam int unsigned DIG_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT} state_t;

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [DIG_W-1:0]  dig_cnt;
  logic [OUT_W-1:0]  value_nxt;
  logic              illegal;
  logic              clear_acc;
  logic              fold_acc;

  assign illegal   = (y == 3'b100);
  assign clear_acc = en && (state == IDLE) && (DELAY != 0);
  assign fold_acc  = en && ((state == COLLECT) || ((state == IDLE) && (DELAY == 0)));

`ifdef ONLINE_OTF_CONVERSION_EN
  // Q holds the value, QM holds value-1; both built by digit concatenation.
  logic [OUT_W-1:0] q, qm, q_base, qm_base, qm_nxt;
  logic [2:0]       y_plus3;

  always_comb begin
    q_base    = (state == IDLE) ? '0 : q;
    qm_base   = (state == IDLE) ? '1 : qm;
    y_plus3   = 3'd3 + y;
    value_nxt = ((y[2] ? qm_base : q_base) << 2) | {{(OUT_W-2){1'b0}}, y[1:0]};
    // Only the illegal -4 digit gives a negative low term and needs a borrow.
    if (!y[2] && (y != 3'd0))
      qm_nxt = (q_base << 2) | {{(OUT_W-2){1'b0}}, 2'(y[1:0] - 2'd1)};
    else
      qm_nxt = (qm_base << 2) + {{(OUT_W-3){y_plus3[2]}}, y_plus3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qm <= '1;
    end else if (clear_acc) begin
      q  <= '0;
      qm <= '1;
    end else if (fold_acc) begin
      q  <= value_nxt;
      qm <= qm_nxt;
    end
  end
`else
  logic [OUT_W-1:0] acc, acc_base;

  always_comb begin
    acc_base  = (state == IDLE) ? '0 : acc;
    value_nxt = (acc_base << 2) + {{(OUT_W-3){y[2]}}, y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc <= '0;
    else if (clear_acc) acc <= '0;
    else if (fold_acc)  acc <= value_nxt;
  end
`endif

  // Stream sequencing and registered outputs; en=0 stalls everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      dig_cnt   <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            busy    <= 1'b1;
            err     <= 1'b0;
            dig_cnt <= '0;
            if (DELAY == 0) begin
              err     <= illegal;
              dig_cnt <= DIG_W'(1);
              state   <= COLLECT;
            end else if (DELAY == 1) begin
              state <= COLLECT;
            end else begin
              skip_cnt <= SKIP_W'(1);
              state    <= SKIP;
            end
          end
          SKIP: begin
            if (skip_cnt == SKIP_W'(DELAY - 1)) begin
              dig_cnt <= '0;
              state   <= COLLECT;
            end else begin
              skip_cnt <= skip_cnt + SKIP_W'(1);
            end
          end
          COLLECT: begin
            if (illegal) err <= 1'b1;
            if (dig_cnt == DIG_W'(DIGITS - 1)) begin
              result    <= value_nxt;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              dig_cnt <= dig_cnt + DIG_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_online_digit_collector.sv
// Directed self-checking bench for online_digit_collector (DIGITS=8, DELAY=2).
module tb_online_digit_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  y;
  logic [17:0] result;
  logic        out_valid;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_a, t_b;

  int s_mix[10]  = '{0, 0, 1, 2, -1, 0, 0, 0, 0, 3};
  int s_neg[10]  = '{0, 0, -3, -3, -3, -3, -3, -3, -3, -3};
  int s_ill[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -4};

  online_digit_collector dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .y         (y),
    .result    (result),
    .out_valid (out_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-digit stream; optional random stalls between digits.
  task automatic run_stream(input int ds[10], input int max_stall,
                            input logic [17:0] exp_res, input logic exp_err,
                            output int last_cyc);
    int first_cyc;
    int stalls;
    int n;
    stalls = 0;
    first_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (max_stall > 0 && i > 0) begin
        n = $urandom_range(max_stall, 1);
        stalls += n;
        en = 1'b0;
        repeat (n) begin
          @(posedge clk); #1;
          check("stall_no_valid", 32'(out_valid), 32'd0);
        end
      end
      en = 1'b1;
      y  = 3'(ds[i]);
      @(posedge clk); #1;
      if (i == 0) begin
        first_cyc = cyc;
        check("busy_after_first", 32'(busy), 32'd1);
        check("err_clear_at_start", 32'(err), 32'd0);
      end
      if (i < 9) check("no_early_valid", 32'(out_valid), 32'd0);
    end
    last_cyc = cyc;
    en = 1'b0;
    check("valid_pulse", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(exp_res));
    check("err", 32'(err), 32'(exp_err));
    check("busy_fall", 32'(busy), 32'd0);
    check("stream_length", 32'(last_cyc - first_cyc), 32'(9 + stalls));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    y   = 3'd0;
    #12;
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Mixed digits, continuous enable
    run_stream(s_mix, 0, 18'h05C03, 1'b0, t_a);
    @(posedge clk); #1;
    check("pulse_one_cycle", 32'(out_valid), 32'd0);
    check("result_hold", 32'(result), 32'h05C03);

    // Most negative legal stream
    run_stream(s_neg, 0, 18'h30001, 1'b0, t_a);

    // Same mixed stream with stalls
    run_stream(s_mix, 3, 18'h05C03, 1'b0, t_a);
    @(posedge clk); #1;

    // Back-to-back streams
    run_stream(s_neg, 0, 18'h30001, 1'b0, t_a);
    run_stream(s_mix, 0, 18'h05C03, 1'b0, t_b);
    check("b2b_spacing", 32'(t_b - t_a), 32'd10);

    // Illegal digit, then a legal stream clears err
    run_stream(s_ill, 0, 18'h3FFFC, 1'b1, t_a);
    check("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    check("err_hold_idle", 32'(err), 32'd1);
    run_stream(s_mix, 0, 18'h05C03, 1'b0, t_a);

    // Abort mid-stream with reset
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      y  = 3'(s_neg[i]);
      @(posedge clk); #1;
    end
    en = 1'b0;
    check("busy_mid_stream", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;
    run_stream(s_mix, 0, 18'h05C03, 1'b0, t_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
